force_window_capture: RTL and testbench



---
 rtl/fwc_pkg.sv | 23 ++
 rtl/fwc_fifo.sv | 70 +++++++
 rtl/force_window_capture.sv | 141 ++++++++++++++
 tb/tb_force_window_capture.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwc_pkg.sv
// Shared types and defaults for the force-window capture monitor.
//   fwc_state_e : window FSM states (IDLE, ACTIVE)
//   fwc_rec_t   : one window record {stray, len, last, first}, first in LSBs
//   FWC_*       : default widths/depth used by the top and its consumers
package fwc_pkg;

  localparam int FWC_DATA_W = 8;
  localparam int FWC_DEPTH  = 4;
  localparam int FWC_LEN_W  = 8;

  typedef enum logic [0:0] {
    FWC_IDLE   = 1'b0,
    FWC_ACTIVE = 1'b1
  } fwc_state_e;

  typedef struct packed {
    logic                  stray;
    logic [FWC_LEN_W-1:0]  len;
    logic [FWC_DATA_W-1:0] last;
    logic [FWC_DATA_W-1:0] first;
  } fwc_rec_t;

endpackage

// File: rtl/fwc_fifo.sv
// Synchronous show-ahead FIFO holding window records.
//   push_i/wdata_i : write request and data
//   pop_i          : read request; rdata_o shows the head entry while not empty
//   full_o/empty_o : occupancy flags
// A push while full is accepted only when a pop happens on the same edge.
module fwc_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  import fwc_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en_s;
  logic             rd_en_s;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_en_s = push_i && (!full_o || pop_i);
  assign rd_en_s = pop_i && !empty_o;
  // Head is forced to zero when empty so the bus is quiet with no record.
  assign rdata_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];

  // Next-state for storage and pointers.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/force_window_capture.sv
// Force-window capture monitor.
//   en_i, o_a_i       : sampled window enable and observed bus
//   clear_i           : clears overflow_o / drop_cnt_o (FIFO and FSM untouched)
//   m_valid_o/ready_i : record drain handshake, m_data_o = {stray,len,last,first}
//   overflow_o        : sticky, a record was dropped on a full FIFO
//   drop_cnt_o        : saturating count of dropped records
// Each contiguous run of en_i=1 samples becomes one record, pushed on the
// first edge that samples en_i=0.
module force_window_capture
  import fwc_pkg::*;
#(
  parameter int DATA_W = FWC_DATA_W,
  parameter int DEPTH  = FWC_DEPTH,
  parameter int LEN_W  = FWC_LEN_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic [DATA_W-1:0]         o_a_i,
  input  logic                      clear_i,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [2*DATA_W+LEN_W:0]   m_data_o,
  output logic                      overflow_o,
  output logic [7:0]                drop_cnt_o
);

  localparam int REC_W = 2*DATA_W + LEN_W + 1;

  fwc_state_e        state_q, state_d;
  logic [DATA_W-1:0] first_q, first_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              stray_q, stray_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic              drop_s;
  logic              stray_now_s;
  logic [REC_W-1:0]  rec_s;

  // Only bit 0 is a live lane; anything above it is a stray.
  assign stray_now_s = |o_a_i[DATA_W-1:1];
  assign rec_s       = {stray_q, len_q, last_q, first_q};
  assign m_valid_o   = !empty_s;
  assign pop_s       = m_valid_o && m_ready_i;
  assign drop_s      = push_s && full_s && !pop_s;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

  // Window FSM: open on first high sample, extend while high, close on low.
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    last_d  = last_q;
    len_d   = len_q;
    stray_d = stray_q;
    push_s  = 1'b0;
    case (state_q)
      FWC_IDLE: begin
        if (en_i) begin
          first_d = o_a_i;
          last_d  = o_a_i;
          len_d   = LEN_W'(1);
          stray_d = stray_now_s;
          state_d = FWC_ACTIVE;
        end else begin
          state_d = FWC_IDLE;
        end
      end
      FWC_ACTIVE: begin
        if (en_i) begin
          last_d  = o_a_i;
          len_d   = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);
          stray_d = stray_q | stray_now_s;
        end else begin
          // This edge's sample is outside the window; record what we have.
          push_s  = 1'b1;
          state_d = FWC_IDLE;
        end
      end
      default: begin
        state_d = FWC_IDLE;
      end
    endcase
  end

  // Drop bookkeeping; clear takes priority over a simultaneous drop.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end else if (drop_s) begin
      overflow_d = 1'b1;
      drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State, window and drop registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FWC_IDLE;
      first_q    <= {DATA_W{1'b0}};
      last_q     <= {DATA_W{1'b0}};
      len_q      <= {LEN_W{1'b0}};
      stray_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      last_q     <= last_d;
      len_q      <= len_d;
      stray_q    <= stray_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fwc_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .wdata_i (rec_s),
    .pop_i   (pop_s),
    .rdata_o (m_data_o),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

endmodule

// File: tb/tb_force_window_capture.sv
// Directed bench for force_window_capture with a record scoreboard.
module tb_force_window_capture;
  import fwc_pkg::*;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int LW = 8;
  localparam int RW = 2*DW + LW + 1;

  typedef logic [DW-1:0] byte_q_t [$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_i = 1'b0;
  logic [DW-1:0] o_a_i = 8'h00;
  logic          clear_i = 1'b0;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [RW-1:0] m_data_o;
  logic          overflow_o;
  logic [7:0]    drop_cnt_o;

  int       checks = 0;
  int       failures = 0;
  int       exp_drop = 0;
  fwc_rec_t sb [$];
  fwc_rec_t mon_exp;
  fwc_rec_t mon_got;
  byte_q_t  wq;

  force_window_capture #(.DATA_W(DW), .DEPTH(DP), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .o_a_i      (o_a_i),
    .clear_i    (clear_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_data_o   (m_data_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Closing sample: the model decides push or drop from its own occupancy.
  task automatic close_window(input fwc_rec_t r);
    en_i = 1'b0;
    if (sb.size() < DP || (m_ready_i && sb.size() > 0)) begin
      sb.push_back(r);
    end else begin
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end
    tick();
  endtask

  task automatic run_window(input byte_q_t vals);
    fwc_rec_t r;
    int n;
    n = vals.size();
    r.first = vals[0];
    r.last  = vals[n-1];
    r.len   = (n > 255) ? 8'hFF : 8'(n);
    r.stray = 1'b0;
    foreach (vals[i]) begin
      r.stray = r.stray | ((vals[i] >> 1) != 8'h00);
      en_i  = 1'b1;
      o_a_i = vals[i];
      tick();
    end
    close_window(r);
  endtask

  task automatic one_window(input logic [DW-1:0] v);
    byte_q_t q;
    q = {v};
    run_window(q);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      tick();
    end
    check({tag, "_pending"}, 32'(sb.size()), 32'd0);
    tick();
    check({tag, "_valid_low"}, 32'(m_valid_o), 32'd0);
  endtask

  // Scoreboard: a record leaving the DUT is checked against the oldest expected.
  always @(negedge clk) begin
    if (rst_n && m_valid_o && m_ready_i) begin
      mon_got = fwc_rec_t'(m_data_o);
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_record observed=0x%0h expected=none", m_data_o);
      end
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        checks++;
        assert (mon_got === mon_exp) else begin
          failures++;
          $error("FAIL record observed first=%0h last=%0h len=%0d stray=%0b expected first=%0h last=%0h len=%0d stray=%0b",
                 mon_got.first, mon_got.last, mon_got.len, mon_got.stray,
                 mon_exp.first, mon_exp.last, mon_exp.len, mon_exp.stray);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 32'(m_valid_o), 32'd0);
    check("rst_data", 32'(m_data_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_drop", 32'(drop_cnt_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // Window of length 5; valid must be up right after the closing edge.
    m_ready_i = 1'b1;
    wq = {8'h00, 8'h01, 8'h01, 8'h00, 8'h01};
    run_window(wq);
    check("len5_valid_after_close", 32'(m_valid_o), 32'd1);
    tick();
    check("len5_valid_drained", 32'(m_valid_o), 32'd0);

    // Stray bit in the middle of a window.
    wq = {8'h01, 8'h81, 8'h00};
    run_window(wq);
    drain("stray");

    // Overflow: six one-cycle windows into a depth-4 FIFO.
    m_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      one_window(8'(i));
    end
    check("ovf_overflow", 32'(overflow_o), 32'd1);
    check("ovf_drop", 32'(drop_cnt_o), 32'(exp_drop));
    check("ovf_drop_two", 32'(drop_cnt_o), 32'd2);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    exp_drop = 0;
    check("clr_overflow", 32'(overflow_o), 32'd0);
    check("clr_drop", 32'(drop_cnt_o), 32'd0);
    check("clr_keeps_fifo", 32'(m_valid_o), 32'd1);
    m_ready_i = 1'b1;
    drain("ovf_drain");

    // Full FIFO: push and pop on the same edge must not drop.
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      one_window(8'(8'h10 + i));
    end
    en_i  = 1'b1;
    o_a_i = 8'h20;
    tick();
    m_ready_i = 1'b1;
    close_window('{stray: 1'b1, len: 8'd1, last: 8'h20, first: 8'h20});
    m_ready_i = 1'b0;
    check("pp_drop", 32'(drop_cnt_o), 32'd0);
    check("pp_overflow", 32'(overflow_o), 32'd0);
    // Still full: one more window must be dropped.
    one_window(8'h30);
    check("pp_full_drop", 32'(drop_cnt_o), 32'(exp_drop));
    check("pp_full_overflow", 32'(overflow_o), 32'd1);
    m_ready_i = 1'b1;
    drain("pp_drain");

    // Length saturation.
    wq = {};
    for (int i = 0; i < 300; i++) begin
      wq.push_back(8'h01);
    end
    run_window(wq);
    drain("sat");
    check("sat_drop_kept", 32'(drop_cnt_o), 32'd1);

    // Asynchronous reset mid-window with a record already queued.
    m_ready_i = 1'b0;
    one_window(8'h02);
    en_i  = 1'b1;
    o_a_i = 8'h33;
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_drop = 0;
    check("arst_valid", 32'(m_valid_o), 32'd0);
    check("arst_data", 32'(m_data_o), 32'd0);
    check("arst_overflow", 32'(overflow_o), 32'd0);
    check("arst_drop", 32'(drop_cnt_o), 32'd0);
    en_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("arst_no_record", 32'(m_valid_o), 32'd0);
    m_ready_i = 1'b1;
    wq = {8'h01, 8'h00};
    run_window(wq);
    drain("arst_next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
